// File: rtl/encoded_pp_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pp_sched_pkg : shared state encoding and command codes for the PP scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
package pp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_SHIFT = 2'b01;
  localparam logic [1:0] CMD_FULL  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/encoded_pp_scheduler_byte_classifier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// byte_classifier : combinational zero / one-hot / multi-bit byte classifier
// Revision: 1.0
// ---------------------------------------------------------------------------
module byte_classifier (
  input  logic [7:0] data,
  output logic       is_zero,
  output logic       is_onehot,
  output logic       is_multi,
  output logic [2:0] pos
);

  logic [3:0] w_cnt;
  logic [2:0] w_hi;

  always_comb begin
    w_cnt = 4'd0;
    w_hi  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_cnt = w_cnt + {3'b000, data[i]};
      if (data[i]) w_hi = 3'(i);
    end
  end

  // Bit 0 is the LSB; the position is only defined for a single set bit.
  assign is_zero   = (w_cnt == 4'd0);
  assign is_onehot = (w_cnt == 4'd1);
  assign is_multi  = (w_cnt > 4'd1);
  assign pos       = is_onehot ? w_hi : 3'd0;

endmodule
`default_nettype wire

// File: rtl/encoded_pp_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// encoded_pp_scheduler : scans a multiplier operand bytewise and issues
// SHIFT / FULL partial-product commands over a valid/ready handshake.
// Revision: 1.0
// ---------------------------------------------------------------------------
module encoded_pp_scheduler
  import pp_sched_pkg::*;
#(
  parameter int NBYTES = 8,
  parameter int CNTW   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [8*NBYTES-1:0]       operand,
  output logic                      busy,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [1:0]                cmd_type,
  output logic [$clog2(NBYTES)-1:0] cmd_byte,
  output logic [2:0]                cmd_shift,
  output logic [7:0]                cmd_data,
  output logic                      cmd_last,
  output logic                      done,
  output logic [CNTW-1:0]           n_skip,
  output logic [CNTW-1:0]           n_shift,
  output logic [CNTW-1:0]           n_full
);

  localparam int IDXW = $clog2(NBYTES);

  state_e              state_q;
  logic [8*NBYTES-1:0] opnd_q;
  logic [IDXW-1:0]     idx_q;
  logic                busy_q, valid_q, done_q, last_q;
  logic [1:0]          type_q;
  logic [IDXW-1:0]     byte_q;
  logic [2:0]          shift_q;
  logic [7:0]          data_q;
  logic [CNTW-1:0]     skip_q, nshift_q, nfull_q;

  logic [NBYTES-1:0]   w_nz;
  logic                w_nz_from, w_nz_above;
  logic [7:0]          w_cur;
  logic                w_is_zero, w_is_onehot, w_is_multi;
  logic [2:0]          w_pos;

  for (genvar g = 0; g < NBYTES; g++) begin : g_nz
    assign w_nz[g] = |opnd_q[8*g +: 8];
  end

  // "Anything left at or above idx" ends the scan; "anything strictly above" marks the last command.
  assign w_nz_from  = |(w_nz >> idx_q);
  assign w_nz_above = |((w_nz >> idx_q) >> 1);
  assign w_cur      = opnd_q[{idx_q, 3'b000} +: 8];

  byte_classifier u_cls (
    .data      (w_cur),
    .is_zero   (w_is_zero),
    .is_onehot (w_is_onehot),
    .is_multi  (w_is_multi),
    .pos       (w_pos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
      type_q   <= CMD_NONE;
      byte_q   <= '0;
      shift_q  <= 3'd0;
      data_q   <= 8'd0;
      skip_q   <= '0;
      nshift_q <= '0;
      nfull_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opnd_q   <= operand;
            idx_q    <= '0;
            skip_q   <= '0;
            nshift_q <= '0;
            nfull_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (!w_nz_from) begin
            skip_q  <= skip_q + (CNTW'(NBYTES) - CNTW'(idx_q));
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (w_is_zero) begin
            skip_q <= skip_q + CNTW'(1);
            idx_q  <= idx_q + IDXW'(1);
          end else begin
            valid_q <= 1'b1;
            type_q  <= w_is_onehot ? CMD_SHIFT : (w_is_multi ? CMD_FULL : CMD_NONE);
            byte_q  <= idx_q;
            shift_q <= w_pos;
            data_q  <= w_cur;
            last_q  <= !w_nz_above;
            if (w_is_onehot) nshift_q <= nshift_q + CNTW'(1);
            else             nfull_q  <= nfull_q + CNTW'(1);
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + IDXW'(1);
              state_q <= SCAN;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          type_q  <= CMD_NONE;
          byte_q  <= '0;
          shift_q <= 3'd0;
          data_q  <= 8'd0;
          last_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign cmd_valid = valid_q;
  assign cmd_type  = type_q;
  assign cmd_byte  = byte_q;
  assign cmd_shift = shift_q;
  assign cmd_data  = data_q;
  assign cmd_last  = last_q;
  assign done      = done_q;
  assign n_skip    = skip_q;
  assign n_shift   = nshift_q;
  assign n_full    = nfull_q;

endmodule
`default_nettype wire

// File: tb/tb_encoded_pp_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_encoded_pp_scheduler : directed + random operands against a byte-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_encoded_pp_scheduler;

  typedef struct packed {
    logic [1:0] t;
    logic [2:0] b;
    logic [2:0] s;
    logic [7:0] d;
    logic       l;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst, start, cmd_ready;
  logic [63:0] operand;
  logic        busy, cmd_valid, cmd_last, done;
  logic [1:0]  cmd_type;
  logic [2:0]  cmd_byte, cmd_shift;
  logic [7:0]  cmd_data;
  logic [3:0]  n_skip, n_shift, n_full;

  int checks = 0;
  int errors = 0;
  int rmode = 0;
  int hold = 0;

  encoded_pp_scheduler #(.NBYTES(8), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .operand(operand),
    .busy(busy), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_byte(cmd_byte), .cmd_shift(cmd_shift),
    .cmd_data(cmd_data), .cmd_last(cmd_last), .done(done),
    .n_skip(n_skip), .n_shift(n_shift), .n_full(n_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int hi_nz(input logic [63:0] op);
    int h = -1;
    for (int b = 0; b < 8; b++) if (op[8*b +: 8] != 8'd0) h = b;
    return h;
  endfunction

  function automatic int lo_nz(input logic [63:0] op);
    int l = -1;
    for (int b = 7; b >= 0; b--) if (op[8*b +: 8] != 8'd0) l = b;
    return l;
  endfunction

  function automatic cmd_t model_nth(input logic [63:0] op, input int n);
    cmd_t c = '0;
    int cnt = 0;
    logic [7:0] v;
    for (int b = 0; b < 8; b++) begin
      v = op[8*b +: 8];
      if (v != 8'd0) begin
        if (cnt == n) begin
          c.t = ($countones(v) == 1) ? 2'b01 : 2'b10;
          c.b = 3'(b);
          c.s = ($countones(v) == 1) ? 3'($clog2(v)) : 3'd0;
          c.d = v;
          c.l = (b == hi_nz(op));
        end
        cnt++;
      end
    end
    return c;
  endfunction

  // ---------------- ready driver ----------------
  initial begin
    cmd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: cmd_ready = 1'b1;
        1: cmd_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (hold > 0 && cmd_valid) begin
            cmd_ready = 1'b0;
            hold--;
          end else begin
            cmd_ready = (hold == 0);
          end
        end
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          active = 0, chk_rst = 0, seen_first = 0;
  int          k, stalls, served, last_k = 0, last_stalls = 0;
  int          e_ncmd, e_shift, e_full, e_skip, e_hi, e_lo, e_total;
  logic [63:0] cur_op;
  logic [11:0] idle_cnt = '0;
  logic [7:0]  mv;

  always @(negedge clk) begin
    if (chk_rst) begin
      chk("rst_outs", {busy, cmd_valid, done, cmd_type, cmd_byte, cmd_shift, cmd_data, cmd_last}, 0);
      chk("rst_cnts", {n_skip, n_shift, n_full}, 0);
      chk_rst = 0;
    end
    if (rst) begin
      chk_rst  = 1;
      active   = 0;
      idle_cnt = '0;
    end else if (active) begin
      k++;
      if (done) begin
        e_total = (e_ncmd == 0) ? 1 : e_hi + 1 + e_ncmd + stalls;
        chk("done_cycle", k, e_total);
        chk("n_skip", n_skip, e_skip);
        chk("n_shift", n_shift, e_shift);
        chk("n_full", n_full, e_full);
        chk("cmds_served", served, e_ncmd);
        chk("done_busy", {busy, cmd_valid}, 2'b10);
        idle_cnt    = {4'(e_skip), 4'(e_shift), 4'(e_full)};
        last_k      = k;
        last_stalls = stalls;
        active      = 0;
      end else begin
        chk("busy", busy, 1);
        if (cmd_valid) begin
          if (served < e_ncmd)
            chk("cmd", {cmd_type, cmd_byte, cmd_shift, cmd_data, cmd_last}, model_nth(cur_op, served));
          else
            chk("extra_cmd", served, e_ncmd - 1);
          if (!seen_first) begin
            chk("first_valid_cycle", k, e_lo + 1);
            seen_first = 1;
          end
          if (cmd_ready) served++;
          else stalls++;
        end
        if (k > 400) begin
          chk("run_timeout", k, 400);
          active = 0;
        end
      end
    end else begin
      chk("idle_outs", {busy, cmd_valid, done, cmd_type}, 0);
      chk("idle_cnts", {n_skip, n_shift, n_full}, idle_cnt);
      if (start) begin
        cur_op = operand;
        e_ncmd = 0; e_shift = 0; e_full = 0;
        for (int b = 0; b < 8; b++) begin
          mv = cur_op[8*b +: 8];
          if (mv != 8'd0) begin
            e_ncmd++;
            if ($countones(mv) == 1) e_shift++;
            else e_full++;
          end
        end
        e_hi       = hi_nz(cur_op);
        e_lo       = lo_nz(cur_op);
        e_skip     = (e_ncmd == 0) ? 8 : e_hi + 1 - e_ncmd;
        k          = -1;
        stalls     = 0;
        served     = 0;
        seen_first = 0;
        active     = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [63:0] op, input int mode, input bit mid);
    bit got = 0;
    rmode = mode;
    hold  = 5;
    @(posedge clk); #1;
    operand = op;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (mid && i == 4) begin
        @(posedge clk); #1;
        operand = 64'h0000_0000_0000_0001;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("done_seen", got, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] r = '0;
    logic [7:0]  v;
    for (int b = 0; b < 8; b++) begin
      case ($urandom_range(0, 3))
        0, 1: v = 8'd0;
        2: v = 8'd1 << $urandom_range(0, 7);
        default: begin
          v = 8'($urandom_range(0, 255));
          while ($countones(v) < 2) v = 8'($urandom_range(0, 255));
        end
      endcase
      r[8*b +: 8] = v;
    end
    return r;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; operand = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("pin_m0", model_nth(64'h8000_0000_0000_0003, 0), {2'b10, 3'd0, 3'd0, 8'h03, 1'b0});
    chk("pin_m1", model_nth(64'h8000_0000_0000_0003, 1), {2'b01, 3'd7, 3'd7, 8'h80, 1'b1});

    run_op(64'h0, 0, 0);
    chk("zero_cycles", last_k, 1);
    chk("zero_cnts", {n_skip, n_shift, n_full}, {4'd8, 4'd0, 4'd0});

    run_op(64'h80, 0, 0);
    chk("b7_cycles", last_k, 2);
    chk("b7_cnts", {n_skip, n_shift, n_full}, {4'd0, 4'd1, 4'd0});

    run_op(64'h8000_0000_0000_0003, 0, 0);
    chk("ends_cycles", last_k, 10);
    chk("ends_cnts", {n_skip, n_shift, n_full}, {4'd6, 4'd1, 4'd1});

    run_op(64'h0000_0000_0000_0500, 2, 0);
    chk("stall_count", last_stalls, 5);
    chk("stall_cycles", last_k, 8);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    chk("ff_cycles", last_k, 16);
    chk("ff_cnts", {n_skip, n_shift, n_full}, {4'd0, 4'd0, 4'd8});

    // Reset while a command is stalled in ISSUE.
    rmode = 3;
    @(posedge clk); #1;
    operand = 64'h300;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !cmd_valid; i++) @(negedge clk);
    chk("rst_pre_valid", cmd_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rmode = 0;

    run_op(64'h10, 0, 0);
    chk("post_rst_cycles", last_k, 2);
    chk("post_rst_cnts", {n_skip, n_shift, n_full}, {4'd0, 4'd1, 4'd0});

    for (int n = 0; n < 40; n++) run_op(rand_op(), 1, 0);
    for (int n = 0; n < 5; n++) run_op({$urandom, $urandom}, 1, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoded_pp_scheduler.md
# encoded_pp_scheduler

Sequencer for the low-power encoded multiplier datapath. Scans a 64-bit multiplier operand one byte at a time and classifies each byte as zero, one-hot or multi-bit. Zero bytes are skipped. One-hot bytes become shift-only partial-product commands carrying a 3-bit position. Multi-bit bytes become full 8-bit partial-product commands. Sits between the mantissa unpack stage and the partial-product/accumulate array, and issues commands over a valid/ready handshake.

## Interface
Parameters:
- NBYTES, 8, number of operand bytes scanned; operand width is 8*NBYTES.
- CNTW, 4, width of statistics counters; must hold NBYTES.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  launch request; sampled only in IDLE.
- operand  in  8*NBYTES  multiplier operand; captured on accepted start.
- busy  out  1  high whenever state is not IDLE.
- cmd_valid  out  1  command present.
- cmd_ready  in  1  datapath accepts command.
- cmd_type  out  2  01 = SHIFT, 10 = FULL; 00 when idle.
- cmd_byte  out  $clog2(NBYTES)  byte index of command.
- cmd_shift  out  3  one-hot bit position; meaningful for SHIFT only, 0 for FULL.
- cmd_data  out  8  raw byte value.
- cmd_last  out  1  no nonzero byte above cmd_byte.
- done  out  1  one-cycle completion pulse.
- n_skip, n_shift, n_full  out  CNTW each  per-operation byte counts.

## Operation
- States: IDLE, SCAN, ISSUE, DONE.
- IDLE: on start=1, capture operand, set idx=0, clear the three counters, go to SCAN.
- SCAN handles one byte per cycle:
  - If no byte at index ≥ idx is nonzero: go to DONE. The skipped remainder (NBYTES−idx) is added to n_skip.
  - Else if byte[idx] is zero: n_skip++, idx++, stay in SCAN.
  - Else: register the cmd fields, increment n_shift or n_full, go to ISSUE.
- Classification:
  - popcount 0 → skip.
  - popcount 1 → SHIFT, cmd_shift = index of the set bit.
  - popcount ≥2 → FULL, cmd_shift = 0.
- ISSUE:
  - cmd_valid=1, all cmd fields held stable.
  - On cmd_ready=1: if cmd_last, go to DONE; else idx++ and go to SCAN.
- DONE: done=1 for one cycle, then IDLE. Counters hold their values until the next accepted start.
- start while busy is ignored; the operand is not re-captured.
- rst in any state:
  - next cycle: IDLE, all outputs 0, counters 0.
  - an in-flight command is dropped.
  - no done pulse.

## Timing
- Reset values: busy, cmd_valid, done, cmd_* and all counters = 0.
- Cycle numbering: start is sampled at edge E0. All outputs are registered.
- All-zero operand: SCAN after E0; done high after E1; IDLE after E2.
- First nonzero byte at index j: cmd_valid rises after edge E(j+1).
- Per nonzero byte: at least 2 cycles (SCAN + ISSUE). Per zero byte below the last nonzero byte: 1 cycle.
- Worst case, all bytes FULL with cmd_ready tied high: done high after edge E(2·NBYTES).
- cmd fields change only on the SCAN→ISSUE transition; they are stable throughout backpressure.
- cmd_last=1 is asserted on exactly one command per operation, unless the operand is all zero (no commands).

## Structure
- Package pp_sched_pkg holds:
  - state enum {IDLE, SCAN, ISSUE, DONE};
  - cmd_type constants CMD_NONE=2'b00, CMD_SHIFT=2'b01, CMD_FULL=2'b10.
- Sub-module byte_classifier: purely combinational, 8-bit in; outputs is_zero, is_onehot, is_multi, pos[2:0].
  - pos equals the set-bit index when one-hot, else 0.
  - Matches the one-hot encoding convention of the existing gate-level encoder.
- A per-byte nonzero vector plus a "nonzero at or above idx" reduction drives both the SCAN exit decision and cmd_last.

## Test plan
- operand=0, start pulse → no cmd_valid; done after E1; n_skip=8, n_shift=0, n_full=0.
- operand=0x80, ready=1 → one command: SHIFT, byte 0, shift 7, last=1, issued after E1; done after E2; n_shift=1, n_skip=0.
- operand=0x8000_0000_0000_0003, ready=1 → command FULL, byte 0, data 0x03, last=0; then six skip cycles; then SHIFT, byte 7, shift 7, last=1. Final counts n_full=1, n_shift=1, n_skip=6.
- operand=0x0000_0000_0000_0500, cmd_ready held low 5 cycles → cmd_valid and all cmd fields stable for 5 cycles (FULL, byte 1, data 0x05); accepted on the 6th cycle; done follows.
- operand=all 0xFF, ready=1 → 8 FULL commands, byte indices 0..7 ascending; done after E16. A start pulse mid-run is ignored, with no change to the command sequence.
- rst asserted while in ISSUE → next cycle busy=0, cmd_valid=0, counters=0, no done pulse. A following start with operand 0x10 completes normally: SHIFT, byte 0, shift 4.
